// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter/sequencer that shares one DATA_W-bit
// holding register among N_REQ requesters. A grant is registered in IDLE, and
// the granted word is written (with a one-cycle ack) in WRITE.
// Optional build macro REG_SHARE_LOCK_EN adds i_lock and a burst counter that
// lets one owner do up to MAX_LOCK back-to-back writes before release.
module reg_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 8,
    localparam int IW      = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_valor,
`ifdef REG_SHARE_LOCK_EN
    input  logic [N_REQ-1:0]        i_lock,
`endif
    output logic [DATA_W-1:0]       o_valor,
    output logic [N_REQ-1:0]        o_grant,
    output logic [IW-1:0]           o_owner,
    output logic [N_REQ-1:0]        o_ack,
    output logic                    o_busy
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   valor_n;
    logic [N_REQ-1:0]    grant_n;
    logic [IW-1:0]       owner_n;
    logic [N_REQ-1:0]    ack_n;
    logic                busy_n;
    // Binary index of the current grant, kept alongside the one-hot o_grant
    // so WRITE can select the data slice without a one-hot decode.
    logic [IW-1:0]       gidx, gidx_n;
    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [IW:0]         cand;
`ifdef REG_SHARE_LOCK_EN
    logic [7:0]          cnt, cnt_n;
`endif

    // Round-robin search: first set request at or after (owner+1), wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, o_owner} + (IW+1)'(1) + (IW+1)'(i);
            if (cand >= (IW+1)'(N_REQ))
                cand = cand - (IW+1)'(N_REQ);
            if (!win_found && i_req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        valor_n = o_valor;
        grant_n = o_grant;
        owner_n = o_owner;
        ack_n   = '0;
        gidx_n  = gidx;
`ifdef REG_SHARE_LOCK_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_n = N_REQ'(1) << win_idx;
                    gidx_n  = win_idx;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (i_req[gidx]) begin
                    valor_n = i_valor[gidx*DATA_W +: DATA_W];
                    ack_n   = o_grant;
                    owner_n = gidx;
`ifdef REG_SHARE_LOCK_EN
                    // Hold the grant for another write while the owner keeps
                    // its lock and the burst limit is not reached.
                    if (i_lock[gidx] && (cnt < 8'(MAX_LOCK - 1))) begin
                        cnt_n = cnt + 8'd1;
                    end else begin
                        cnt_n   = '0;
                        grant_n = '0;
                        state_n = IDLE;
                    end
`else
                    grant_n = '0;
                    state_n = IDLE;
`endif
                end else begin
                    // Request withdrawn: drop the grant without writing.
                    grant_n = '0;
                    state_n = IDLE;
`ifdef REG_SHARE_LOCK_EN
                    cnt_n   = '0;
`endif
                end
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset gives requester 0 top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            o_valor <= '0;
            o_grant <= '0;
            o_owner <= IW'(N_REQ - 1);
            o_ack   <= '0;
            o_busy  <= 1'b0;
            gidx    <= '0;
`ifdef REG_SHARE_LOCK_EN
            cnt     <= '0;
`endif
        end else begin
            state   <= state_n;
            o_valor <= valor_n;
            o_grant <= grant_n;
            o_owner <= owner_n;
            o_ack   <= ack_n;
            o_busy  <= busy_n;
            gidx    <= gidx_n;
`ifdef REG_SHARE_LOCK_EN
            cnt     <= cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (N_REQ=4, DATA_W=8, MAX_LOCK=3).
module tb_reg_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  i_req = '0;
    logic [31:0] i_valor = '0;
`ifdef REG_SHARE_LOCK_EN
    logic [3:0]  i_lock = '0;
`endif
    logic [7:0]  o_valor;
    logic [3:0]  o_grant;
    logic [1:0]  o_owner;
    logic [3:0]  o_ack;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    reg_share_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_LOCK(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_valor (i_valor),
`ifdef REG_SHARE_LOCK_EN
        .i_lock  (i_lock),
`endif
        .o_valor (o_valor),
        .o_grant (o_grant),
        .o_owner (o_owner),
        .o_ack   (o_ack),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] v, input logic [3:0] g,
                             input logic [1:0] own, input logic [3:0] a, input logic b);
        check({tag, ".valor"}, 32'(o_valor), 32'(v));
        check({tag, ".grant"}, 32'(o_grant), 32'(g));
        check({tag, ".owner"}, 32'(o_owner), 32'(own));
        check({tag, ".ack"},   32'(o_ack),   32'(a));
        check({tag, ".busy"},  32'(o_busy),  32'(b));
    endtask

    initial begin
        // Reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #1 check_all("reset_async", 8'h00, 4'b0000, 2'd3, 4'b0000, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check_all("reset_idle", 8'h00, 4'b0000, 2'd3, 4'b0000, 1'b0);

        // Single request from requester 2; other slices hold junk.
        i_valor = 32'h77A5_6655;
        i_req   = 4'b0100;
        tick();
        check_all("single_grant", 8'h00, 4'b0100, 2'd3, 4'b0000, 1'b1);
        tick();
        check_all("single_write", 8'hA5, 4'b0000, 2'd2, 4'b0100, 1'b0);
        i_req = 4'b0000;
        tick();
        check_all("single_hold", 8'hA5, 4'b0000, 2'd2, 4'b0000, 1'b0);

        // Reset in the middle of a WRITE cancels the write.
        i_req = 4'b0001;
        tick();
        check("midrst_pre.grant", 32'(o_grant), 32'h1);
        rst = 1'b1;
        #1 check_all("midrst", 8'h00, 4'b0000, 2'd3, 4'b0000, 1'b0);
        #1 rst = 1'b0;
        i_req = 4'b0000;
        tick();
        check_all("midrst_after", 8'h00, 4'b0000, 2'd3, 4'b0000, 1'b0);

        // Round robin with all four requesting: 0,1,2,3,0.
        i_valor = 32'h1312_1110;
        i_req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", 32'(o_grant), 32'(4'b0001 << (k % 4)));
            check("rr_noack", 32'(o_ack), 32'h0);
            tick();
            check("rr_ack",   32'(o_ack),   32'(4'b0001 << (k % 4)));
            check("rr_valor", 32'(o_valor), 32'(8'h10 + 8'(k % 4)));
            check("rr_owner", 32'(o_owner), 32'(k % 4));
        end
        i_req = 4'b0000;
        tick();
        check_all("rr_idle", 8'h10, 4'b0000, 2'd0, 4'b0000, 1'b0);

        // Withdrawal during WRITE: no write, owner unchanged.
        i_valor = 32'h4444_BB44;
        i_req   = 4'b0010;
        tick();
        check_all("wd_grant", 8'h10, 4'b0010, 2'd0, 4'b0000, 1'b1);
        i_req = 4'b0000;
        tick();
        check_all("wd_abort", 8'h10, 4'b0000, 2'd0, 4'b0000, 1'b0);
        tick();
        check_all("wd_idle", 8'h10, 4'b0000, 2'd0, 4'b0000, 1'b0);

        // Move owner to 3, then requesters 0 and 3 race: 0 wins on wrap.
        i_valor = 32'hC3C2_C1C0;
        i_req   = 4'b1000;
        tick();
        check("wrap_set.grant", 32'(o_grant), 32'h8);
        tick();
        check_all("wrap_set", 8'hC3, 4'b0000, 2'd3, 4'b1000, 1'b0);
        i_req = 4'b1001;
        tick();
        check_all("wrap_g0", 8'hC3, 4'b0001, 2'd3, 4'b0000, 1'b1);
        tick();
        check_all("wrap_w0", 8'hC0, 4'b0000, 2'd0, 4'b0001, 1'b0);
        i_req = 4'b1000;
        tick();
        check_all("wrap_g3", 8'hC0, 4'b1000, 2'd0, 4'b0000, 1'b1);
        tick();
        check_all("wrap_w3", 8'hC3, 4'b0000, 2'd3, 4'b1000, 1'b0);
        i_req = 4'b0000;
        tick();

`ifdef REG_SHARE_LOCK_EN
        // Locked burst: requester 0 gets MAX_LOCK=3 back-to-back writes.
        i_valor = 32'h0000_D1D0;
        i_req   = 4'b0011;
        i_lock  = 4'b0001;
        tick();
        check_all("lock_g0", 8'hC3, 4'b0001, 2'd3, 4'b0000, 1'b1);
        tick();
        check_all("lock_w1", 8'hD0, 4'b0001, 2'd0, 4'b0001, 1'b1);
        tick();
        check_all("lock_w2", 8'hD0, 4'b0001, 2'd0, 4'b0001, 1'b1);
        tick();
        check_all("lock_w3", 8'hD0, 4'b0000, 2'd0, 4'b0001, 1'b0);
        i_req = 4'b0010;
        tick();
        check_all("lock_g1", 8'hD0, 4'b0010, 2'd0, 4'b0000, 1'b1);
        tick();
        check_all("lock_w4", 8'hD1, 4'b0000, 2'd1, 4'b0010, 1'b0);
        i_req  = 4'b0000;
        i_lock = 4'b0000;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
